logs_pwm_demod: RTL and testbench
=================================

LOGS_PWM_DEMOD -- requirements
Module: logs_pwm_demod

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 8, log2 of the averaging window length WIN in clk cycles (valid range 2..12).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of input synchronizer flops (minimum 2).
REQ-003 SHALL have input clk, 1 bit, the clock; all logic is clocked on its rising edge.
REQ-004 SHALL have input reset, 1 bit, synchronous, active-high.
REQ-005 SHALL have input enable, 1 bit; high runs the demodulator.
REQ-006 SHALL have input pwm_in, 1 bit, the asynchronous PWM audio stream (the output of a PWM audio generator).
REQ-007 SHALL have output sample, WIN_LOG2+1 bits, the number of high cycles in a window (0..WIN).
REQ-008 SHALL have output edges, WIN_LOG2+1 bits, the number of transitions counted in a window.
REQ-009 SHALL have output sample_valid, 1 bit, high while the output register holds an unconsumed result.
REQ-010 SHALL have input sample_ready, 1 bit; the consumer accepts a result on any cycle with sample_valid & sample_ready.
REQ-011 SHALL have output overrun, 1 bit, a sticky flag set when a result is dropped.

Function
REQ-012 SHALL pass pwm_in through a SYNC_STAGES-flop synchronizer to form bit s; all counting uses s only.
REQ-013 SHALL implement an FSM with states IDLE, FLUSH and RUN.
REQ-014 SHALL, in IDLE, hold the window counter, ones counter and edge counter at 0, and go to FLUSH when enable=1.
REQ-015 SHALL stay in FLUSH for exactly SYNC_STAGES cycles, discarding s; on leaving, load prev<=s and enter RUN with window counter 0.
REQ-016 SHALL, in RUN on each cycle, advance the window counter modulo WIN, add s to the ones counter, and add (s != prev) to the edge counter, then set prev<=s.
REQ-017 SHALL, on the cycle with window counter = WIN-1, form the results ones+s and edges+(s!=prev), and restart both counters at 0 on the next cycle with no gap cycle.
REQ-018 SHALL carry prev across window boundaries, so that a transition on the first cycle of a window is counted in that window.
REQ-019 SHALL load the results into sample/edges and set sample_valid on the following edge if sample_valid=0, or if sample_valid=1 and sample_ready=1 on that cycle (accept and refill in the same cycle, no bubble).
REQ-020 SHALL, if sample_valid=1 and sample_ready=0 at window end, drop the new results, retain the old ones, and set overrun=1.
REQ-021 SHALL clear sample_valid after an accept when no new result lands in the same cycle.
REQ-022 SHALL, when enable=0 in FLUSH or RUN, return to IDLE on the next edge and discard any partial window, even if it is at window counter = WIN-1.
REQ-023 SHALL leave sample, edges and sample_valid unaffected by enable deassertion; a pending result remains consumable.
REQ-024 SHALL clear overrun only on reset or on the IDLE-to-FLUSH transition.
REQ-025 SHALL saturate nothing: the counters are WIN_LOG2+1 bits wide, so WIN fits exactly.
REQ-026 SHALL have a first-result latency of SYNC_STAGES + WIN + 1 cycles after enable rises (plus the synchronizer delay on pwm_in).

Reset
REQ-027 SHALL, on reset=1, force state IDLE; all counters, prev, sample, edges, sample_valid, overrun and the synchronizer flops to 0.
REQ-028 SHALL give reset priority over enable and sample_ready, aborting any window in progress with no result produced.

Structure
REQ-029 SHALL keep the FSM state encoding and the WIN_LOG2/SYNC_STAGES defaults in the shared logs package, alongside the existing logistic-map audio constants.
REQ-030 SHALL implement the synchronizer as the sub-module logs_sync (parameter STAGES), reusable for other asynchronous inputs.
REQ-031 SHALL keep the window accumulation and the output holding register in this module; no FIFO.

Verification (WIN_LOG2=8, SYNC_STAGES=2)
REQ-032 SHALL check: pwm_in held at 1, enable=1, ready=1 -> first valid 259 cycles after enable; sample=256 and edges=0 every window.
REQ-033 SHALL check: a square wave of period 16 with 4 high cycles (25% duty), ready=1 -> steady-state sample=64, edges=32, one result per 256 cycles, no gaps.
REQ-034 SHALL check: ready=0 for 3 windows -> the first result is held unchanged, overrun=1 after the second window ends, and one accept then releases it.
REQ-035 SHALL check: ready pulsed high exactly on a window-end cycle -> the old result is accepted, the new one loads with sample_valid staying 1, and overrun stays 0.
REQ-036 SHALL check: enable dropped at window counter 255 -> no new result; re-enable -> the next result arrives 259 cycles later and overrun is cleared.
REQ-037 SHALL check: reset asserted mid-window with sample_valid=1 -> all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/logs_pkg.sv
// rtl/logs_pkg.sv - shared logs constants, demodulator defaults and FSM encoding
package logs_pkg;

  // Logistic-map audio generator constants (Q2.14 fixed point)
  localparam int          LOGS_MAP_WIDTH = 16;
  localparam logic [15:0] LOGS_MAP_R     = 16'hE666;
  localparam logic [15:0] LOGS_MAP_SEED  = 16'h2000;
  localparam int          LOGS_PWM_BITS  = 8;

  // PWM demodulator defaults
  localparam int LOGS_WIN_LOG2    = 8;
  localparam int LOGS_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } demod_state_t;

endpackage

// File: rtl/logs_sync.sv
// rtl/logs_sync.sv - multi-flop synchronizer for asynchronous single-bit inputs
module logs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/logs_pwm_demod.sv
// rtl/logs_pwm_demod.sv - windowed duty-cycle and edge-count demodulator for PWM audio
module logs_pwm_demod
  import logs_pkg::*;
#(
  parameter int WIN_LOG2    = LOGS_WIN_LOG2,
  parameter int SYNC_STAGES = LOGS_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                pwm_in,
  output logic [WIN_LOG2:0]   sample,
  output logic [WIN_LOG2:0]   edges,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun
);

  localparam int CW = WIN_LOG2 + 1;
  localparam int FW = $clog2(SYNC_STAGES + 1);

  demod_state_t state, state_nxt;

  logic                s;
  logic                prev;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [CW-1:0]       ones;
  logic [CW-1:0]       edge_cnt;
  logic [FW-1:0]       flush_cnt;

  logic                win_last;
  logic                win_done;
  logic                toggle;
  logic [CW-1:0]       ones_sum;
  logic [CW-1:0]       edges_sum;

  logs_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pwm_in),
    .q     (s)
  );

  assign win_last  = (win_cnt == {WIN_LOG2{1'b1}});
  assign win_done  = (state == ST_RUN) && enable && win_last;
  assign toggle    = s ^ prev;
  assign ones_sum  = ones + CW'(s);
  assign edges_sum = edge_cnt + CW'(toggle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (flush_cnt == FW'(SYNC_STAGES - 1)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Window accumulation; counters sit at zero outside an enabled RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt   <= '0;
      ones      <= '0;
      edge_cnt  <= '0;
      flush_cnt <= '0;
      prev      <= 1'b0;
    end else begin
      if (state == ST_FLUSH && enable) begin
        flush_cnt <= flush_cnt + 1'b1;
      end else begin
        flush_cnt <= '0;
      end

      if (state == ST_RUN && enable) begin
        win_cnt <= win_cnt + 1'b1;
        prev    <= s;
        if (win_last) begin
          ones     <= '0;
          edge_cnt <= '0;
        end else begin
          ones     <= ones_sum;
          edge_cnt <= edges_sum;
        end
      end else begin
        win_cnt  <= '0;
        ones     <= '0;
        edge_cnt <= '0;
        // Seed prev so the first window's leading transition is judged correctly
        if (state == ST_FLUSH && state_nxt == ST_RUN) prev <= s;
      end
    end
  end

  // Single-entry holding register: refill on accept in the same cycle, drop when full
  always_ff @(posedge clk) begin
    if (reset) begin
      sample       <= '0;
      edges        <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (win_done) begin
        if (!sample_valid || sample_ready) begin
          sample       <= ones_sum;
          edges        <= edges_sum;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      if (state == ST_IDLE && enable) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logs_pwm_demod.sv
// tb/tb_logs_pwm_demod.sv - scoreboard bench for logs_pwm_demod
module tb_logs_pwm_demod;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pwm_in;
  logic [8:0] sample;
  logic [8:0] edges;
  logic       sample_valid;
  logic       sample_ready;
  logic       overrun;

  logic       sq_mode;
  logic       level;
  logic [3:0] ph = 4'd0;

  typedef struct {
    int s;
    int e;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;

  always #5 clk = ~clk;

  // Free-running PWM source: period 16, 4 high cycles, or a constant level
  always @(negedge clk) ph <= ph + 4'd1;
  assign pwm_in = sq_mode ? (ph < 4'd4) : level;

  logs_pwm_demod #(.WIN_LOG2(8), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pwm_in       (pwm_in),
    .sample       (sample),
    .edges        (edges),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!sample_valid && cnt < 600);
  endtask

  task automatic push(input int s, input int e, input int times);
    exp_t x;
    x.s = s;
    x.e = e;
    repeat (times) exp_q.push_back(x);
  endtask

  // Pop and compare on every accepted result
  always @(negedge clk) begin
    if (!reset && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("sb_sample", 32'(sample), x.s);
        check("sb_edges", 32'(edges), x.e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; sample_ready = 1'b0; sq_mode = 1'b0; level = 1'b0;
    tick(3);
    check("rst_sample", 32'(sample), 0);
    check("rst_edges", 32'(edges), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset = 1'b0;
    tick(2);

    // Constant high input
    level = 1'b1; sample_ready = 1'b1;
    tick(4);
    push(256, 0, 3);
    enable = 1'b1;
    wait_valid(n); check("lat_const", n, 259);
    wait_valid(n); check("gap_const1", n, 256);
    wait_valid(n); check("gap_const2", n, 256);
    enable = 1'b0;
    tick(2);
    check("drain_const", exp_q.size(), 0);

    // 25% duty square wave
    sq_mode = 1'b1;
    tick(20);
    push(64, 32, 3);
    enable = 1'b1;
    wait_valid(n); check("lat_sq", n, 259);
    wait_valid(n); check("gap_sq1", n, 256);
    wait_valid(n); check("gap_sq2", n, 256);
    enable = 1'b0;
    tick(2);
    check("drain_sq", exp_q.size(), 0);

    // Consumer stalled across three windows
    sample_ready = 1'b0;
    enable = 1'b1;
    wait_valid(n);
    push(64, 32, 1);
    check("stall_first", 32'(sample), 64);
    tick(255);
    check("ovr_before", 32'(overrun), 0);
    tick(1);
    check("ovr_set", 32'(overrun), 1);
    check("held_w2", 32'(sample), 64);
    tick(256);
    check("held_w3_valid", 32'(sample_valid), 1);
    check("held_w3_edges", 32'(edges), 32);
    sample_ready = 1'b1; enable = 1'b0;
    tick(1);
    check("release_valid", 32'(sample_valid), 0);
    sample_ready = 1'b0;
    tick(5);
    check("ovr_sticky_idle", 32'(overrun), 1);

    // Enable dropped on the last window cycle, then re-enabled
    sq_mode = 1'b0; level = 1'b1;
    tick(5);
    push(256, 0, 1);
    enable = 1'b1;
    wait_valid(n); check("lat_reen0", n, 259);
    check("ovr_cleared", 32'(overrun), 0);
    tick(255);
    enable = 1'b0;
    tick(4);
    check("drop_valid_kept", 32'(sample_valid), 1);
    check("drop_sample_kept", 32'(sample), 256);
    check("drop_no_overrun", 32'(overrun), 0);
    push(256, 0, 1);
    sample_ready = 1'b1; enable = 1'b1;
    wait_valid(n); check("lat_reen1", n, 259);
    enable = 1'b0;
    tick(2);
    check("drain_reen", exp_q.size(), 0);

    // Ready pulsed exactly on a window-end cycle
    sq_mode = 1'b1; sample_ready = 1'b0;
    tick(20);
    enable = 1'b1;
    wait_valid(n);
    push(64, 32, 2);
    tick(255);
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
    check("refill_valid", 32'(sample_valid), 1);
    check("refill_overrun", 32'(overrun), 0);
    check("refill_sample", 32'(sample), 64);
    check("refill_pending", exp_q.size(), 1);
    sample_ready = 1'b1; enable = 1'b0;
    tick(1);
    check("refill_consumed", 32'(sample_valid), 0);
    tick(2);
    check("drain_refill", exp_q.size(), 0);

    // Reset in the middle of a window with a result pending
    sample_ready = 1'b0; enable = 1'b1;
    wait_valid(n);
    tick(100);
    reset = 1'b1;
    tick(1);
    check("mid_rst_sample", 32'(sample), 0);
    check("mid_rst_edges", 32'(edges), 0);
    check("mid_rst_valid", 32'(sample_valid), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    reset = 1'b0; enable = 1'b0;
    tick(3);
    check("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
